// File: rtl/node_stream_out_if.sv
// Node-side send/done port plus host-side read/status port of the stream sink.
// slave is the sink itself; master is whatever drives the node and host sides.
interface node_stream_out_if #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [10:0]      inData;
    logic             send;
    logic             done;
    logic             rd_en;
    logic [10:0]      rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] total;
    logic             range_err;
    logic             clr_err;

    modport master (
        output inData, send, rd_en, clr_err,
        input  done, rd_data, rd_valid, empty, full, level, total, range_err
    );

    modport slave (
        input  inData, send, rd_en, clr_err,
        output done, rd_data, rd_valid, empty, full, level, total, range_err
    );
endinterface

// File: rtl/node_stream_out.sv
// Stream sink for the node mesh: acks upstream words via send/done, queues them
// in a FIFO for host reads, counts accepted words and flags out-of-range values.
module node_stream_out #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    node_stream_out_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic signed [10:0] VAL_MAX = 11'sd999;
    localparam logic signed [10:0] VAL_MIN = -11'sd999;

    typedef enum logic {
        IDLE,
        ACK
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             range_err_q, range_err_d;
    logic [10:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [10:0]      mem_q [DEPTH];

    logic full;
    logic empty;
    logic capture;
    logic pop;
    logic trip;
    logic done;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.send && !full) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs; done is a decode of the registered state only
    always_comb begin
        done    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE:    capture = bus.send && !full;
            ACK:     done = 1'b1;
            default: done = 1'b0;
        endcase
    end

    // Datapath next-state; full/empty come from the registered level, so a
    // pop in the same cycle never frees a slot for a capture.
    always_comb begin
        pop  = bus.rd_en && !empty;
        trip = capture &&
               (($signed(bus.inData) > VAL_MAX) || ($signed(bus.inData) < VAL_MIN));

        wr_ptr_d    = capture ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        total_d     = capture ? total_q + 1'b1 : total_q;
        rd_valid_d  = pop;
        rd_data_d   = pop ? mem_q[rd_ptr_q] : rd_data_q;

        level_d = level_q;
        unique case ({capture, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        range_err_d = range_err_q;
        if (trip) begin
            range_err_d = 1'b1;
        end else if (bus.clr_err) begin
            range_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            total_q     <= '0;
            range_err_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            total_q     <= total_d;
            range_err_q <= range_err_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= bus.inData;
        end
    end

    assign bus.done      = done;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.level     = level_q;
    assign bus.total     = total_q;
    assign bus.range_err = range_err_q;
endmodule

// File: tb/tb_node_stream_out.sv
// Directed bench for node_stream_out: a queue-based model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_node_stream_out;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    node_stream_out_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    node_stream_out #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [10:0]      mq[$];
    logic [CNT_W-1:0] m_total = '0;
    logic             m_err   = 1'b0;
    logic             m_done  = 1'b0;
    logic             m_rv    = 1'b0;
    logic [10:0]      m_rd    = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Word-level behaviour: a word is taken when not acking and not full;
    // a pop takes the oldest word; the ack follows every accepted word.
    task automatic model_step();
        bit cap, pop, trip;
        int v;
        if (rst) begin
            mq.delete();
            m_total = '0;
            m_err   = 1'b0;
            m_done  = 1'b0;
            m_rv    = 1'b0;
            m_rd    = '0;
        end else begin
            cap  = !m_done && bus.send && (mq.size() < DEPTH);
            pop  = bus.rd_en && (mq.size() != 0);
            v    = int'($signed(bus.inData));
            trip = cap && (v > 999 || v < -999);
            m_rv = pop;
            if (pop) m_rd = mq.pop_front();
            if (cap) begin
                mq.push_back(bus.inData);
                m_total = m_total + 1'b1;
            end
            if (trip) m_err = 1'b1;
            else if (bus.clr_err) m_err = 1'b0;
            m_done = cap;
        end
    endtask

    task automatic compare_all();
        chk("done",      bus.done,      m_done);
        chk("rd_valid",  bus.rd_valid,  m_rv);
        chk("rd_data",   bus.rd_data,   m_rd);
        chk("level",     bus.level,     mq.size());
        chk("empty",     bus.empty,     mq.size() == 0);
        chk("full",      bus.full,      mq.size() == DEPTH);
        chk("total",     bus.total,     m_total);
        chk("range_err", bus.range_err, m_err);
    endtask

    // Inputs change at the falling edge; the model steps on the rising edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic push_word(input logic [10:0] w);
        bit got;
        got = 0;
        bus.send   = 1'b1;
        bus.inData = w;
        for (int g = 0; g < 8 && !got; g++) begin
            tick();
            if (bus.done) got = 1;
        end
        bus.send = 1'b0;
        chk("push_ack", got, 1);
        tick();
    endtask

    task automatic read_word(output logic [10:0] d);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("read_valid", bus.rd_valid, 1);
        d = bus.rd_data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [10:0] d;
        logic [10:0] e;
        int k;
        int pulses;
        int bvals[6];

        bus.inData  = '0;
        bus.send    = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;

        // Reset state
        do_reset();
        chk("rst_done",  bus.done, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full",  bus.full, 0);
        chk("rst_total", bus.total, 0);
        chk("rst_rdata", bus.rd_data, 0);
        chk("rst_rvalid", bus.rd_valid, 0);
        chk("rst_err",   bus.range_err, 0);

        // Held send with constant 5: ack every other cycle
        bus.send = 1'b1;
        bus.inData = 11'd5;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("t1_done", bus.done, (i % 2 == 1) ? 1 : 0);
            chk("t1_level", bus.level, (i + 1) / 2);
            pulses += int'(bus.done);
        end
        bus.send = 1'b0;
        chk("t1_pulses", pulses, 3);
        for (int i = 0; i < 3; i++) begin
            read_word(d);
            chk("t1_read", d, 5);
        end
        chk("t1_empty", bus.empty, 1);

        // Fill to DEPTH, check backpressure, one read frees one slot
        do_reset();
        k = 0;
        bus.send = 1'b1;
        bus.inData = 11'(k);
        for (int g = 0; g < 200 && k < 32; g++) begin
            tick();
            if (bus.done) begin
                k++;
                bus.inData = 11'(k);
            end
        end
        chk("t2_fill", k, 32);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_bp_done", bus.done, 0);
            chk("t2_bp_full", bus.full, 1);
        end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("t2_first", bus.rd_data, 0);
        chk("t2_pop_level", bus.level, 31);
        chk("t2_pop_done", bus.done, 0);
        for (int g = 0; g < 10 && k < 33; g++) begin
            tick();
            if (bus.done) begin
                k++;
                bus.inData = 11'(k);
            end
        end
        chk("t2_extra", k, 33);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_bp2_done", bus.done, 0);
        end
        bus.send = 1'b0;
        chk("t2_total33", bus.total, 33);
        for (int i = 0; i < 32; i++) begin
            read_word(d);
            chk("t2_drain", d, i + 1);
        end
        for (int i = 33; i < 40; i++) push_word(11'(i));
        chk("t2_total40", bus.total, 40);
        for (int i = 33; i < 40; i++) begin
            read_word(d);
            chk("t2_tail", d, i);
        end

        // Range boundaries, clear, and set-beats-clear
        do_reset();
        bvals = '{-999, 999, 1000, -1000, -1024, 1023};
        push_word(11'(bvals[0]));
        chk("t3_err_m999", bus.range_err, 0);
        push_word(11'(bvals[1]));
        chk("t3_err_999", bus.range_err, 0);
        push_word(11'(bvals[2]));
        chk("t3_err_1000", bus.range_err, 1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("t3_clr", bus.range_err, 0);
        push_word(11'(bvals[3]));
        chk("t3_err_m1000", bus.range_err, 1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("t3_clr2", bus.range_err, 0);
        push_word(11'(bvals[4]));
        chk("t3_err_m1024", bus.range_err, 1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        bus.send = 1'b1;
        bus.inData = 11'(bvals[5]);
        bus.clr_err = 1'b1;
        tick();
        bus.send = 1'b0;
        bus.clr_err = 1'b0;
        chk("t3_set_wins", bus.range_err, 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            read_word(d);
            e = 11'(bvals[i]);
            chk("t3_readback", d, e);
        end

        // Read on empty: no strobe, data holds
        bus.rd_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t4_rv", bus.rd_valid, 0);
            chk("t4_rd", bus.rd_data, 11'h3FF);
        end
        bus.rd_en = 1'b0;

        // Capture and pop together at level 4
        do_reset();
        for (int i = 10; i < 14; i++) push_word(11'(i));
        chk("t5_level4", bus.level, 4);
        bus.send = 1'b1;
        bus.inData = 11'd14;
        bus.rd_en = 1'b1;
        tick();
        bus.send = 1'b0;
        bus.rd_en = 1'b0;
        chk("t5_level", bus.level, 4);
        chk("t5_rd", bus.rd_data, 10);
        chk("t5_done", bus.done, 1);
        tick();
        for (int i = 11; i < 15; i++) begin
            read_word(d);
            chk("t5_order", d, i);
        end

        // Reset during the ack cycle
        do_reset();
        bus.send = 1'b1;
        bus.inData = 11'd77;
        tick();
        chk("t6_ack", bus.done, 1);
        bus.send = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_done", bus.done, 0);
        chk("t6_level", bus.level, 0);
        chk("t6_total", bus.total, 0);
        push_word(11'd88);
        chk("t6_total1", bus.total, 1);
        read_word(d);
        chk("t6_read", d, 88);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
